// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the ALU datapath: single-cycle logic/arith ops and an iterative shift-add MUL.
// Build option: define MUL_EARLY_EXIT_EN to end MUL as soon as the remaining multiplier bits are zero.
//
// state  | meaning
// S_IDLE | waiting for start; op and operands latched on the accepting edge
// S_EXEC | one-cycle compute of AND/OR/ADD/SUB/SLT/invalid
// S_MUL  | one shift-add iteration per cycle through the shared adder
// S_DONE | one-cycle done pulse, then back to idle
module alu_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Zero,
  output logic             Overflow,
  output logic             InvalidOp
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_p;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_res_hi;
  logic               r_zero;
  logic               r_ovf;
  logic               r_inv;

  logic               w_is_mul;
  logic               w_is_sub;
  logic [WIDTH-1:0]   w_add_a;
  logic [WIDTH-1:0]   w_add_b;
  logic               w_add_ci;
  logic [WIDTH:0]     w_sum;
  logic               w_add_ovf;
  logic               w_slt;
  logic [2*WIDTH-1:0] w_p_next;
  logic [2*WIDTH-1:0] w_p_final;
  logic [WIDTH-1:0]   w_q_next;
  logic               w_mul_last;
  logic [WIDTH-1:0]   w_ex_res;
  logic               w_ex_ovf;
  logic               w_ex_inv;

  // One adder serves both ADD/SUB and the MUL partial-product accumulate.
  assign w_is_mul  = (r_state == S_MUL);
  assign w_is_sub  = (r_op == OP_SUB);
  assign w_add_a   = w_is_mul ? r_p[2*WIDTH-1:WIDTH] : r_a;
  assign w_add_b   = w_is_mul ? (r_b[0] ? r_a : '0) : (w_is_sub ? ~r_b : r_b);
  assign w_add_ci  = !w_is_mul && w_is_sub;
  assign w_sum     = {1'b0, w_add_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_add_ci};
  assign w_add_ovf = (w_add_a[WIDTH-1] == w_add_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_add_a[WIDTH-1]);
  assign w_slt     = ($signed(r_a) < $signed(r_b));

  assign w_p_next  = {w_sum, r_p[WIDTH-1:1]};
  assign w_q_next  = r_b >> 1;

`ifdef MUL_EARLY_EXIT_EN
  // Remaining iterations would only shift P, so apply that shift in one go.
  assign w_mul_last = (r_cnt == LAST) || (w_q_next == '0);
  assign w_p_final  = w_p_next >> (LAST - r_cnt);
`else
  assign w_mul_last = (r_cnt == LAST);
  assign w_p_final  = w_p_next;
`endif

  always_comb begin
    w_ex_res = '0;
    w_ex_ovf = 1'b0;
    w_ex_inv = 1'b0;
    case (r_op)
      OP_AND:  w_ex_res = r_a & r_b;
      OP_OR:   w_ex_res = r_a | r_b;
      OP_ADD,
      OP_SUB: begin
        w_ex_res = w_sum[WIDTH-1:0];
        w_ex_ovf = w_add_ovf;
      end
      OP_SLT:  w_ex_res = {{(WIDTH-1){1'b0}}, w_slt};
      3'b110,
      3'b111:  w_ex_inv = 1'b1;
      default: w_ex_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (op == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC:  w_state_nxt = S_DONE;
      S_MUL:   if (w_mul_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_EXEC) || (r_state == S_MUL);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_p      <= '0;
      r_cnt    <= '0;
      r_res    <= '0;
      r_res_hi <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_inv    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op  <= op;
            r_a   <= A;
            r_b   <= B;
            r_p   <= '0;
            r_cnt <= '0;
          end
        end
        S_EXEC: begin
          r_res    <= w_ex_res;
          r_res_hi <= '0;
          r_zero   <= (w_ex_res == '0);
          r_ovf    <= w_ex_ovf;
          r_inv    <= w_ex_inv;
        end
        S_MUL: begin
          r_p   <= w_p_next;
          r_b   <= w_q_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_mul_last) begin
            r_res    <= w_p_final[WIDTH-1:0];
            r_res_hi <= w_p_final[2*WIDTH-1:WIDTH];
            r_zero   <= (w_p_final == '0);
            r_ovf    <= 1'b0;
            r_inv    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign Result    = r_res;
  assign ResultHi  = r_res_hi;
  assign Zero      = r_zero;
  assign Overflow  = r_ovf;
  assign InvalidOp = r_inv;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: directed plan cases plus random ops against a plain-arithmetic model.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy, done, Zero, Overflow, InvalidOp;
  logic [31:0] Result, ResultHi;

  alu_seq_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .Result(Result), .ResultHi(ResultHi),
    .Zero(Zero), .Overflow(Overflow), .InvalidOp(InvalidOp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
    logic        inv;
    int          lat;
    int          k;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb_, r;
    logic [63:0] prod;
    e = '{default: 0};
    sa = $signed(a);
    sb_ = $signed(b);
    e.lat = 1;
    case (o)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd2: begin r = sa + sb_; e.res = r[31:0]; e.ovf = (r != longint'(int'(r))); end
      3'd3: begin r = sa - sb_; e.res = r[31:0]; e.ovf = (r != longint'(int'(r))); end
      3'd4: e.res = (sa < sb_) ? 32'd1 : 32'd0;
      3'd5: begin
        prod = {32'd0, a} * {32'd0, b};
        e.res = prod[31:0];
        e.hi  = prod[63:32];
`ifdef MUL_EARLY_EXIT_EN
        for (int i = 0; i < 32; i++) if (b[i]) e.lat = i + 1;
`else
        e.lat = 32;
`endif
      end
      default: e.inv = 1'b1;
    endcase
    e.zero = (e.res == 0) && (e.hi == 0);
    return e;
  endfunction

  // Operands are scrambled right after acceptance to expose any re-sampling.
  task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom_range(0, 7)); A = $urandom; B = $urandom;
    e = model(o, a, b);
    e.k = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 200);
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done within %0d cycles, required a done pulse", t);
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_result"}, Result, 0);
    chk({tag, "_resulthi"}, ResultHi, 0);
    chk({tag, "_zero"}, Zero, 0);
    chk({tag, "_ovf"}, Overflow, 0);
    chk({tag, "_inv"}, InvalidOp, 0);
  endtask

  always @(negedge clk) begin
    if (busy) begin
      busy_cnt++;
    end else if (done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done with empty scoreboard, required none (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("result", Result, mon_e.res);
        chk("resulthi", ResultHi, mon_e.hi);
        chk("zero", Zero, mon_e.zero);
        chk("overflow", Overflow, mon_e.ovf);
        chk("invalidop", InvalidOp, mon_e.inv);
        chk("latency", cyc - mon_e.k, mon_e.lat);
        chk("busy_cycles", busy_cnt, mon_e.lat);
      end
      busy_cnt = 0;
    end else begin
      busy_cnt = 0;
    end
  end

  logic [31:0] specials[5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;

    send(3'd0, 32'hF0F0F0F0, 32'h0FF00FF0); wait_done();
    chk("and_const", Result, 32'h00F000F0);
    send(3'd2, 32'h7FFFFFFF, 32'h00000001); wait_done();
    chk("add_ovf_const", {Result, 31'd0, Overflow}, {32'h80000000, 32'd1});
    send(3'd3, 32'h00000005, 32'h00000005); wait_done();
    chk("sub_zero_const", {Zero, Overflow}, 2'b10);
    send(3'd4, 32'hFFFFFFFF, 32'h00000001); wait_done();
    chk("slt_const", Result, 32'd1);
    send(3'd4, 32'h7FFFFFFF, 32'h80000000); wait_done();
    send(3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_done();
    chk("mul_const", {ResultHi, Result}, 64'hFFFFFFFE_00000001);
    send(3'd6, 32'h12345678, 32'h1); wait_done();
    send(3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_done();
    send(3'd5, 32'd7, 32'd0); wait_done();
    send(3'd5, 32'd1, 32'h80000000); wait_done();

    // Handshake: stray starts during MUL and during DONE must be dropped.
    send(3'd5, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd0; A = 32'h1; B = 32'h1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    start = 1'b1; op = 3'd0; A = 32'hFFFF; B = 32'hFFFF;
    @(negedge clk);
    start = 1'b0;
    chk("hs_result", Result, 32'h0000000F);
    chk("hs_idle", {busy, done}, 2'b00);
    @(negedge clk);
    chk("hs_still_idle", {busy, done}, 2'b00);

    // Reset mid-MUL: abort without a done pulse.
    send(3'd5, 32'h12345678, 32'h9ABCDEF1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    check_cleared("midrst");
    repeat (40) @(negedge clk);
    chk("midrst_quiet", {busy, done}, 2'b00);
    send(3'd1, 32'h0000FFFF, 32'hFFFF0000); wait_done();
    chk("or_const", Result, 32'hFFFFFFFF);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 5) == 0) b = b >> $urandom_range(0, 31);
      send(o, a, b);
      wait_done();
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencing controller for the 32-bit ALU datapath, built on the bitwise AND/OR and adder slices.
- Accepts one operation at a time through a start/busy/done handshake and registers the result.
- Single-cycle ops (AND, OR, ADD, SUB, SLT) complete in one execute cycle.
- MUL reuses the adder iteratively as an unsigned shift-add multiplier producing a 64-bit product.

Parameters:
- WIDTH, 32, operand/result width. MUL iteration count equals WIDTH. Only 32 is verified.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- op  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT (signed), 101 MUL (unsigned), 11x invalid
- A  input  WIDTH  operand A; captured on the accepting edge
- B  input  WIDTH  operand B; captured on the accepting edge
- busy  output  1  high in EXEC and MUL states
- done  output  1  one-cycle completion pulse (DONE state)
- Result  output  WIDTH  result, or low product word for MUL
- ResultHi  output  WIDTH  high product word for MUL; 0 for all other ops
- Zero  output  1  1 when Result==0 and ResultHi==0
- Overflow  output  1  signed overflow for ADD/SUB; 0 for all other ops
- InvalidOp  output  1  1 when the completed op was 11x

Behaviour:
- Reset: clk is the only clock; reset is synchronous, active-high, and takes priority over all other logic.
  - On reset: state=IDLE; busy, done, Result, ResultHi, Zero, Overflow, InvalidOp all =0; internal registers cleared.
  - Reset mid-operation aborts it. No done pulse is produced and outputs clear on the following cycle.
- States:
  - IDLE: if start=1 at edge k, latch op, A, B, then go to EXEC (op != MUL) or MUL (op == MUL). start=0 stays in IDLE.
  - EXEC: at edge k+1, compute and register the outputs, then go to DONE. done is high in the cycle after edge k+1.
  - MUL: registers are product P (2*WIDTH bits, cleared at accept), multiplicand M=A, multiplier Q=B, counter cnt (cleared at accept).
    - Each edge: if Q[0], P[2W-1:W] += M (with carry into bit 2W). Then P and Q shift right by 1, cnt++.
    - After the iteration with cnt==WIDTH-1, go to DONE.
    - Completion edge is k+32. Result=P[31:0], ResultHi=P[63:32].
  - DONE: done=1 for exactly one cycle, busy=0, then return to IDLE. start is ignored while in DONE.
- Outputs are registered, updated only on the completion edge, and held until the next completion or reset.
- start while busy or done is ignored. Operands and op are not re-sampled.
- Arithmetic:
  - ADD/SUB wrap modulo 2^32.
  - Overflow = operand signs agree (after B inversion for SUB) and the result sign differs.
  - SLT: Result=1 if $signed(A) < $signed(B), else 0. Compare is exact, not subtract-sign (correct under overflow).
  - AND/OR are bitwise.
- Invalid op: takes the EXEC path. Result=0, ResultHi=0, Zero=1, InvalidOp=1, done pulses normally.

Optional Feature:
- Macro MUL_EARLY_EXIT_EN.
- Defined: in MUL, if the shifted Q is 0 after an iteration, go to DONE on that same edge. P is right-aligned by the remaining shift count (WIDTH-1-cnt) on the exit edge, so the product is bit-identical to the full run.
  - Latency = index of the highest set bit of B, plus 1. B=0 takes 1 iteration.
- Undefined: always WIDTH iterations, regardless of B.

Test Plan:
- AND: A=F0F0F0F0, B=0FF00FF0, start at edge k -> done high in the cycle after edge k+1; Result=00F000F0, ResultHi=0, Zero=0, busy high for exactly 1 cycle.
- ADD/SUB: ADD 7FFFFFFF+00000001 -> Result=80000000, Overflow=1, Zero=0. SUB 00000005-00000005 -> Result=0, Zero=1, Overflow=0. SLT A=FFFFFFFF, B=00000001 -> Result=1.
- MUL: FFFFFFFF*FFFFFFFF, macro off -> busy high 32 cycles, done after edge k+32; ResultHi=FFFFFFFE, Result=00000001.
- Handshake: start MUL 3*5, then pulse start with op=AND at cycles k+5 and in DONE -> both ignored; Result=0000000F, exactly one done pulse.
- Reset: assert reset during MUL iteration 10 -> next cycle busy=0, done=0, all outputs 0, no done pulse. A new start with OR 0000FFFF|FFFF0000 -> Result=FFFFFFFF.
- Early exit with macro defined: MUL 3*5 -> done after edge k+3, Result=0000000F. MUL 7*0 -> done after edge k+1, Result=0, Zero=1. MUL 1*80000000 -> 32 iterations, Result=80000000.
